pixel_sequencer: RTL and testbench

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

---
 rtl/pixel_sequencer_if.sv | 37 +++
 rtl/pixel_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_pixel_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_sequencer_if.sv
// Bundle of triangle-setup, pixel-issue and status signals for pixel_sequencer.
// master = the sequencer itself, slave = its upstream/evaluator environment.
interface pixel_sequencer_if #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);

    logic [XW-1:0] bbox_min_x;
    logic [XW-1:0] bbox_max_x;
    logic [YW-1:0] bbox_min_y;
    logic [YW-1:0] bbox_max_y;
    logic          tri_valid;
    logic          tri_ready;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pix_valid;
    logic          pix_ready;
    logic          eval_busy;
    logic          tri_done;
    logic          busy;
    logic [CW-1:0] pixel_count;

    modport master (
        input  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
        input  tri_valid, pix_ready, eval_busy,
        output tri_ready, pixel_x, pixel_y, pix_valid, tri_done, busy, pixel_count
    );

    modport slave (
        output bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
        output tri_valid, pix_ready, eval_busy,
        input  tri_ready, pixel_x, pixel_y, pix_valid, tri_done, busy, pixel_count
    );
endinterface

// File: rtl/pixel_sequencer.sv
// Row-major bounding-box pixel walker feeding a triangle evaluator, one pixel per cycle.
// Optional issued-pixel counter enabled by defining PIXEL_SEQ_COUNT_EN.
module pixel_sequencer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic              clk,
    input  logic              rst,
    pixel_sequencer_if.master bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;

    logic [XW-1:0] min_x_r;
    logic [XW-1:0] max_x_r;
    logic [YW-1:0] min_y_r;
    logic [YW-1:0] max_y_r;

    logic [XW-1:0] pixel_x_r;
    logic [YW-1:0] pixel_y_r;
    logic          pix_valid_r;
    logic          tri_ready_r;
    logic          tri_done_r;
    logic          busy_r;

    logic [XW-1:0] pixel_x_nx_s;
    logic [YW-1:0] pixel_y_nx_s;
    logic          pix_valid_nx_s;
    logic          tri_ready_nx_s;
    logic          tri_done_nx_s;
    logic          busy_nx_s;

    logic [XW-1:0] clamp_max_x_s;
    logic [YW-1:0] clamp_max_y_s;
    logic          bbox_empty_s;
    logic          handshake_s;
    logic          accept_s;
    logic          row_end_s;
    logic          last_pix_s;

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (v > X_LAST) ? X_LAST : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (v > Y_LAST) ? Y_LAST : v;
    endfunction

    // Only the max edges are clamped; an off-screen min simply yields an empty box.
    assign clamp_max_x_s = clamp_x(bus.bbox_max_x);
    assign clamp_max_y_s = clamp_y(bus.bbox_max_y);
    assign bbox_empty_s  = (bus.bbox_min_x > clamp_max_x_s) || (bus.bbox_min_y > clamp_max_y_s);

    assign handshake_s = bus.tri_valid && tri_ready_r;
    assign accept_s    = pix_valid_r && bus.pix_ready;
    assign row_end_s   = (pixel_x_r == max_x_r);
    assign last_pix_s  = row_end_s && (pixel_y_r == max_y_r);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_nx_s = bbox_empty_s ? ST_DONE : ST_SCAN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (accept_s && last_pix_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (!bus.eval_busy) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered outputs and the pixel walk
    always_comb begin
        pixel_x_nx_s = pixel_x_r;
        pixel_y_nx_s = pixel_y_r;
        if (handshake_s && !bbox_empty_s) begin
            pixel_x_nx_s = bus.bbox_min_x;
            pixel_y_nx_s = bus.bbox_min_y;
        end else if (accept_s && !last_pix_s) begin
            if (row_end_s) begin
                pixel_x_nx_s = min_x_r;
                pixel_y_nx_s = pixel_y_r + Y_ONE;
            end else begin
                pixel_x_nx_s = pixel_x_r + X_ONE;
                pixel_y_nx_s = pixel_y_r;
            end
        end else begin
            pixel_x_nx_s = pixel_x_r;
            pixel_y_nx_s = pixel_y_r;
        end
        // Flags are derived from the next state so each output lines up with its state.
        pix_valid_nx_s = (state_nx_s == ST_SCAN);
        tri_ready_nx_s = (state_nx_s == ST_IDLE);
        tri_done_nx_s  = (state_nx_s == ST_DONE);
        busy_nx_s      = (state_nx_s != ST_IDLE);
    end

    // Latched bounding box for the triangle in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x_r <= {XW{1'b0}};
            max_x_r <= {XW{1'b0}};
            min_y_r <= {YW{1'b0}};
            max_y_r <= {YW{1'b0}};
        end else if (handshake_s) begin
            min_x_r <= bus.bbox_min_x;
            max_x_r <= clamp_max_x_s;
            min_y_r <= bus.bbox_min_y;
            max_y_r <= clamp_max_y_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x_r   <= {XW{1'b0}};
            pixel_y_r   <= {YW{1'b0}};
            pix_valid_r <= 1'b0;
            tri_ready_r <= 1'b0;
            tri_done_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            pixel_x_r   <= pixel_x_nx_s;
            pixel_y_r   <= pixel_y_nx_s;
            pix_valid_r <= pix_valid_nx_s;
            tri_ready_r <= tri_ready_nx_s;
            tri_done_r  <= tri_done_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign bus.pixel_x   = pixel_x_r;
    assign bus.pixel_y   = pixel_y_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.tri_ready = tri_ready_r;
    assign bus.tri_done  = tri_done_r;
    assign bus.busy      = busy_r;

`ifdef PIXEL_SEQ_COUNT_EN
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
    logic [CW-1:0] count_r;

    // Issued-pixel counter, held after completion until the next triangle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (handshake_s) begin
            count_r <= {CW{1'b0}};
        end else if (accept_s) begin
            count_r <= count_r + C_ONE;
        end
    end

    assign bus.pixel_count = count_r;
`else
    assign bus.pixel_count = {CW{1'b0}};
`endif

    pixel_sequencer_checker #(
        .XW (XW),
        .YW (YW)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .tri_ready (bus.tri_ready),
        .pix_valid (bus.pix_valid),
        .pix_ready (bus.pix_ready),
        .pixel_x   (bus.pixel_x),
        .pixel_y   (bus.pixel_y),
        .tri_done  (bus.tri_done),
        .busy      (bus.busy)
    );
endmodule

// Protocol properties of the sequencer outputs.
module pixel_sequencer_checker #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input logic          clk,
    input logic          rst,
    input logic          tri_ready,
    input logic          pix_valid,
    input logic          pix_ready,
    input logic [XW-1:0] pixel_x,
    input logic [YW-1:0] pixel_y,
    input logic          tri_done,
    input logic          busy
);
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (pix_valid && !pix_ready) |=> (pix_valid && $stable(pixel_x) && $stable(pixel_y)));

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        tri_done |=> !tri_done);

    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        tri_ready |-> (!pix_valid && !busy && !tri_done));
endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: directed and randomized triangles
// compared against a queue-based model of the expected pixel stream.
module tb_pixel_sequencer;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cnt;

    pixel_sequencer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();
    pixel_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int exp_count(input int c);
`ifdef PIXEL_SEQ_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Runs one triangle. Entered and left at 1 time unit after a rising edge.
    task automatic run_tri(input int mnx, input int mxx, input int mny, input int mxy,
                           input bit rnd, input logic [15:0] rpat, input int rlen,
                           input logic [15:0] bpat, input int blen, input int abort_n,
                           output bit aborted);
        int q_x[$];
        int q_y[$];
        int cx, cy, idx, cyc, limit, wait_n;
        bit in_drain, exp_done, rdy, bsy;
        aborted = 1'b0;
        wait_n = 0;
        while (bus.tri_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        checks++;
        if (bus.tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL tri_ready_wait: got %b want 1", bus.tri_ready);
        end
        bus.bbox_min_x = XW'(mnx);
        bus.bbox_max_x = XW'(mxx);
        bus.bbox_min_y = YW'(mny);
        bus.bbox_max_y = YW'(mxy);
        bus.tri_valid  = 1'b1;
        bus.pix_ready  = 1'b0;
        bus.eval_busy  = 1'($urandom_range(0, 1));
        @(posedge clk);
        cx = (mxx > WIDTH - 1) ? WIDTH - 1 : mxx;
        cy = (mxy > HEIGHT - 1) ? HEIGHT - 1 : mxy;
        for (int y = mny; y <= cy; y++) begin
            for (int x = mnx; x <= cx; x++) begin
                q_x.push_back(x);
                q_y.push_back(y);
            end
        end
        limit = 20 * (q_x.size() + 2) + 100;
        cnt = 0; in_drain = 1'b0; exp_done = (q_x.size() == 0); idx = 0; cyc = 0;
        #1;
        bus.tri_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        while (1) begin
            checks++;
            if (bus.tri_done !== exp_done) begin
                errors++;
                $display("FAIL tri_done: got %b want %b (box %0d,%0d-%0d,%0d)", bus.tri_done, exp_done, mnx, mny, mxx, mxy);
            end
            checks++;
            if (bus.pix_valid !== (q_x.size() != 0)) begin
                errors++;
                $display("FAIL pix_valid: got %b want %b (accepted %0d)", bus.pix_valid, (q_x.size() != 0), cnt);
            end
            if (q_x.size() != 0) begin
                checks++;
                if (bus.pixel_x !== XW'(q_x[0]) || bus.pixel_y !== YW'(q_y[0])) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d) want (%0d,%0d)", bus.pixel_x, bus.pixel_y, q_x[0], q_y[0]);
                end
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.tri_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: got busy=%b ready=%b want 1/0", bus.busy, bus.tri_ready);
            end
            checks++;
            if (bus.pixel_count !== CW'(exp_count(cnt))) begin
                errors++;
                $display("FAIL pixel_count: got %0d want %0d", bus.pixel_count, exp_count(cnt));
            end
            if (exp_done) break;
            if (abort_n > 0 && cnt == abort_n) begin
                aborted = 1'b1;
                break;
            end
            if (cyc >= limit) begin
                checks++; errors++;
                $display("FAIL timeout: triangle not finished after %0d cycles", cyc);
                break;
            end
            if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
                bsy = ($urandom_range(0, 2) == 0);
                bus.tri_valid = 1'($urandom_range(0, 1));
            end else begin
                rdy = (idx < rlen) ? rpat[idx] : 1'b1;
                bsy = (idx < blen) ? bpat[idx] : 1'b0;
            end
            bus.pix_ready = rdy;
            bus.eval_busy = bsy;
            idx++; cyc++;
            @(posedge clk);
            exp_done = 1'b0;
            if (in_drain && !bsy) begin
                exp_done = 1'b1;
                in_drain = 1'b0;
            end else if (q_x.size() != 0 && rdy) begin
                void'(q_x.pop_front());
                void'(q_y.pop_front());
                cnt++;
                if (q_x.size() == 0) in_drain = 1'b1;
            end
            #1;
        end
        bus.tri_valid = 1'b0;
        bus.pix_ready = 1'b0;
        bus.eval_busy = 1'b0;
        if (!aborted) begin
            @(posedge clk); #1;
            checks++;
            if (bus.tri_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.tri_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after: got ready=%b busy=%b pv=%b done=%b want 1/0/0/0",
                         bus.tri_ready, bus.busy, bus.pix_valid, bus.tri_done);
            end
            checks++;
            if (bus.pixel_count !== CW'(exp_count(cnt))) begin
                errors++;
                $display("FAIL count_held: got %0d want %0d", bus.pixel_count, exp_count(cnt));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tri_valid = 1'b0; bus.pix_ready = 1'b0; bus.eval_busy = 1'b0;
        bus.bbox_min_x = '0; bus.bbox_max_x = '0; bus.bbox_min_y = '0; bus.bbox_max_y = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.tri_ready !== 1'b0 || bus.pix_valid !== 1'b0 || bus.tri_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b pv=%b done=%b busy=%b want 0", bus.tri_ready, bus.pix_valid, bus.tri_done, bus.busy);
        end
        checks++;
        if (bus.pixel_x !== '0 || bus.pixel_y !== '0 || bus.pixel_count !== '0) begin
            errors++;
            $display("FAIL reset_values: got x=%0d y=%0d cnt=%0d want 0", bus.pixel_x, bus.pixel_y, bus.pixel_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", bus.tri_ready);
        end
    endtask

    task automatic test_basic();
        bit ab;
        run_tri(2, 4, 3, 4, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
        checks++;
        if (cnt != 6) begin
            errors++;
            $display("FAIL basic_pixels: got %0d want 6", cnt);
        end
    endtask

    task automatic test_single();
        bit ab;
        run_tri(5, 5, 5, 5, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
    endtask

    task automatic test_empty();
        bit ab;
        run_tri(10, 9, 0, 0, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
        run_tri(0, 0, 5, 4, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
    endtask

    // A max_y of 300 does not fit YW bits, so the largest representable value stands in.
    task automatic test_clamp();
        bit ab;
        run_tri(318, 400, 238, 255, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
        run_tri(319, 511, 0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
    endtask

    task automatic test_stall();
        bit ab;
        run_tri(0, 1, 0, 0, 1'b0, 16'b1001, 4, 16'b11111, 5, 0, ab);
    endtask

    task automatic test_reset_mid();
        bit ab;
        run_tri(0, 7, 0, 7, 1'b0, 16'h0, 0, 16'h0, 0, 10, ab);
        checks++;
        if (!ab) begin
            errors++;
            $display("FAIL abort_reached: got %b want 1", ab);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.tri_done !== 1'b0 || bus.busy !== 1'b0 || bus.tri_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got pv=%b done=%b busy=%b ready=%b want 0", bus.pix_valid, bus.tri_done, bus.busy, bus.tri_ready);
        end
        checks++;
        if (bus.pixel_count !== '0 || bus.pixel_x !== '0 || bus.pixel_y !== '0) begin
            errors++;
            $display("FAIL abort_values: got cnt=%0d x=%0d y=%0d want 0", bus.pixel_count, bus.pixel_x, bus.pixel_y);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.tri_done !== 1'b0 || bus.pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold: got done=%b pv=%b want 0", bus.tri_done, bus.pix_valid);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: got ready=%b want 1", bus.tri_ready);
        end
    endtask

    task automatic test_random();
        bit ab;
        int mnx, mxx, mny, mxy;
        for (int i = 0; i < 14; i++) begin
            mnx = $urandom_range(0, 330);
            mxx = mnx + $urandom_range(0, 5) - 1;
            mny = $urandom_range(0, 250);
            mxy = mny + $urandom_range(0, 4) - 1;
            if (mxx < 0) mxx = 0;
            if (mxy < 0) mxy = 0;
            if (mxy > 255) mxy = 255;
            run_tri(mnx, mxx, mny, mxy, 1'b1, 16'h0, 0, 16'h0, 0, 0, ab);
        end
    endtask

    task automatic test_back_to_back();
        bit ab;
        run_tri(100, 103, 50, 50, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
        run_tri(0, 0, 0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 0, ab);
        run_tri(7, 9, 9, 10, 1'b1, 16'h0, 0, 16'h0, 0, 0, ab);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty();
        test_clamp();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
